// File: rtl/fifo_sync_ctrl.sv
// rtl/fifo_sync_ctrl.sv - single-clock FIFO controller driving a registered-read dual-port RAM
//
// Purpose: accepts push/pop requests, drives the RAM write and read ports, returns
// read data with a 1-cycle valid strobe, and maintains occupancy, status flags and
// sticky error flags.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   wr_en, wr_data                push request and data
//   rd_en                         pop request
//   rd_data, rd_valid             pop data (RAM passthrough) and its strobe
//   full, empty                   registered occupancy limits
//   almost_full, almost_empty     registered programmable thresholds
//   count                         occupancy 0..DEPTH
//   overflow, underflow           sticky error flags, cleared only by reset
//   ram_w_en/addr/data            RAM write port
//   ram_r_en/addr, ram_r_data     RAM read port (data arrives one cycle after ram_r_en)

module fifo_sync_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic                  ram_r_en,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_r_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_V    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_V    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

  // Pointers carry one extra bit so they roll over modulo 2*DEPTH; only the low
  // ADDR_WIDTH bits address the RAM.
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic af_q, af_d;
  logic ae_q, ae_d;
  logic rd_valid_q, rd_valid_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  logic push_ok;
  logic pop_ok;

  always_comb begin
    // Gating on the registered flags keeps a same-cycle push/pop from ever hitting
    // the same RAM address, and makes a push while full fail even if a pop frees space.
    push_ok = wr_en & ~full_q;
    pop_ok  = rd_en & ~empty_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase

    // Flags are derived from the next count so they are exact the cycle after the edge.
    full_d  = (count_d == DEPTH_V);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_V);
    ae_d    = (count_d <= AE_V);

    rd_valid_d  = pop_ok;
    overflow_d  = overflow_q | (wr_en & full_q);
    underflow_d = underflow_q | (rd_en & empty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign ram_w_en     = push_ok;
  assign ram_w_addr   = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_w_data   = wr_data;
  assign ram_r_en     = pop_ok;
  assign ram_r_addr   = rd_ptr_q[ADDR_WIDTH-1:0];

  assign rd_data      = ram_r_data;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb/tb_fifo_sync_ctrl.sv - directed self-checking bench for fifo_sync_ctrl with a registered-read RAM model
module tb_fifo_sync_ctrl;

  localparam int AW = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;
  logic          ram_w_en;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic          ram_r_en;
  logic [AW-1:0] ram_r_addr;
  logic [DW-1:0] ram_r_data = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_n = 0;   // accepted pushes since last reset
  int rd_n = 0;   // accepted pops since last reset

  fifo_sync_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_LEVEL(3), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow),
    .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  // Registered-read dual-port RAM, one cycle read latency.
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
    if (ram_r_en) ram_r_data <= mem[ram_r_addr];
  end

  // Drive inputs at the falling edge and settle; registered outputs then reflect all
  // earlier steps and combinational RAM strobes reflect this step's inputs.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else pass_cnt++;
    total_cnt++; if (almost_empty !== 1'b1) $display("FAIL reset_ae got %b want 1", almost_empty); else pass_cnt++;
    total_cnt++; if (full !== 1'b0 || almost_full !== 1'b0) $display("FAIL reset_full got %b%b want 00", full, almost_full); else pass_cnt++;
    total_cnt++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", rd_valid); else pass_cnt++;
    total_cnt++; if (ram_w_en !== 1'b0 || ram_r_en !== 1'b0) $display("FAIL reset_ram_en got %b%b want 00", ram_w_en, ram_r_en); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL reset_err got %b%b want 00", overflow, underflow); else pass_cnt++;
    rst = 1'b0;
    wr_n = 0; rd_n = 0;
    step(0, 0, 0);
    total_cnt++; if (empty !== 1'b1 || count !== 3'd0) $display("FAIL idle_after_release got empty=%b count=%0d want 1/0", empty, count); else pass_cnt++;
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 4; i++) begin
      step(1, 8'hA0 + 8'(i), 0);
      total_cnt++; if (ram_w_en !== 1'b1) $display("FAIL fill_w_en[%0d] got %b want 1", i, ram_w_en); else pass_cnt++;
      total_cnt++; if (ram_w_addr !== 2'(wr_n)) $display("FAIL fill_w_addr[%0d] got %0d want %0d", i, ram_w_addr, wr_n % 4); else pass_cnt++;
      total_cnt++; if (count !== 3'(i)) $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); else pass_cnt++;
      total_cnt++; if (almost_full !== (i >= 3)) $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, i >= 3); else pass_cnt++;
      total_cnt++; if (almost_empty !== (i <= 1)) $display("FAIL fill_ae[%0d] got %b want %b", i, almost_empty, i <= 1); else pass_cnt++;
      wr_n++;
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1);
      if (i == 0) begin
        total_cnt++; if (full !== 1'b1 || count !== 3'd4) $display("FAIL full_after_4 got full=%b count=%0d want 1/4", full, count); else pass_cnt++;
      end
      total_cnt++; if (ram_r_en !== 1'b1 || ram_r_addr !== 2'(rd_n)) $display("FAIL drain_r[%0d] got en=%b addr=%0d want 1/%0d", i, ram_r_en, ram_r_addr, rd_n % 4); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (rd_valid !== 1'b1 || rd_data !== 8'hA0 + 8'(i - 1)) $display("FAIL drain_data[%0d] got v=%b d=%h want 1/%h", i - 1, rd_valid, rd_data, 8'hA0 + 8'(i - 1)); else pass_cnt++;
      end
      rd_n++;
    end
    step(0, 0, 0);
    total_cnt++; if (rd_valid !== 1'b1 || rd_data !== 8'hA3) $display("FAIL drain_data[3] got v=%b d=%h want 1/a3", rd_valid, rd_data); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1 || count !== 3'd0) $display("FAIL drain_empty got empty=%b count=%0d want 1/0", empty, count); else pass_cnt++;
    step(0, 0, 0);
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL drain_valid_drop got %b want 0", rd_valid); else pass_cnt++;
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 4; i++) begin
      step(1, 8'hB0 + 8'(i), 0);
      wr_n++;
    end
    step(1, 8'hFF, 0);
    total_cnt++; if (ram_w_en !== 1'b0 || full !== 1'b1) $display("FAIL ovf_blocked got w_en=%b full=%b want 0/1", ram_w_en, full); else pass_cnt++;
    // Push while full with a simultaneous pop: pop accepted, push still rejected.
    step(1, 8'hFF, 1);
    total_cnt++; if (count !== 3'd4 || overflow !== 1'b1) $display("FAIL ovf_flag got count=%0d ovf=%b want 4/1", count, overflow); else pass_cnt++;
    total_cnt++; if (ram_w_en !== 1'b0 || ram_r_en !== 1'b1) $display("FAIL ovf_pop_same_cycle got w=%b r=%b want 0/1", ram_w_en, ram_r_en); else pass_cnt++;
    rd_n++;
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 1);
      if (i == 1) begin
        total_cnt++; if (full !== 1'b0 || count !== 3'd3) $display("FAIL ovf_full_drop got full=%b count=%0d want 0/3", full, count); else pass_cnt++;
      end
      total_cnt++; if (rd_valid !== 1'b1 || rd_data !== 8'hB0 + 8'(i - 1)) $display("FAIL ovf_data[%0d] got v=%b d=%h want 1/%h", i - 1, rd_valid, rd_data, 8'hB0 + 8'(i - 1)); else pass_cnt++;
      rd_n++;
    end
    step(0, 0, 0);
    total_cnt++; if (rd_valid !== 1'b1 || rd_data !== 8'hB3) $display("FAIL ovf_data[3] got v=%b d=%h want 1/b3", rd_valid, rd_data); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1 || empty !== 1'b1) $display("FAIL ovf_sticky got ovf=%b empty=%b want 1/1", overflow, empty); else pass_cnt++;
  endtask

  task automatic test_underflow;
    step(0, 0, 1);
    total_cnt++; if (ram_r_en !== 1'b0) $display("FAIL unf_r_en got %b want 0", ram_r_en); else pass_cnt++;
    step(0, 0, 0);
    total_cnt++; if (rd_valid !== 1'b0 || underflow !== 1'b1) $display("FAIL unf_flag got v=%b unf=%b want 0/1", rd_valid, underflow); else pass_cnt++;
    step(0, 0, 0);
    total_cnt++; if (underflow !== 1'b1 || count !== 3'd0) $display("FAIL unf_sticky got unf=%b count=%0d want 1/0", underflow, count); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    step(1, 8'hC0, 0); wr_n++;
    step(1, 8'hC1, 0); wr_n++;
    for (int i = 0; i < 10; i++) begin
      step(1, 8'hC2 + 8'(i), 1);
      total_cnt++; if (ram_w_en !== 1'b1 || ram_r_en !== 1'b1) $display("FAIL b2b_en[%0d] got w=%b r=%b want 1/1", i, ram_w_en, ram_r_en); else pass_cnt++;
      total_cnt++; if (ram_w_addr !== 2'(wr_n) || ram_r_addr !== 2'(rd_n)) $display("FAIL b2b_addr[%0d] got w=%0d r=%0d want %0d/%0d", i, ram_w_addr, ram_r_addr, wr_n % 4, rd_n % 4); else pass_cnt++;
      total_cnt++; if (count !== 3'd2) $display("FAIL b2b_count[%0d] got %0d want 2", i, count); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (rd_valid !== 1'b1 || rd_data !== 8'hC0 + 8'(i - 1)) $display("FAIL b2b_data[%0d] got v=%b d=%h want 1/%h", i, rd_valid, rd_data, 8'hC0 + 8'(i - 1)); else pass_cnt++;
      end
      wr_n++; rd_n++;
    end
    step(0, 0, 1); rd_n++;
    total_cnt++; if (rd_valid !== 1'b1 || rd_data !== 8'hC9 || count !== 3'd2) $display("FAIL b2b_tail got v=%b d=%h c=%0d want 1/c9/2", rd_valid, rd_data, count); else pass_cnt++;
    step(0, 0, 1); rd_n++;
    total_cnt++; if (rd_data !== 8'hCA) $display("FAIL b2b_drain0 got %h want ca", rd_data); else pass_cnt++;
    step(0, 0, 0);
    total_cnt++; if (rd_data !== 8'hCB || empty !== 1'b1) $display("FAIL b2b_drain1 got d=%h empty=%b want cb/1", rd_data, empty); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    step(1, 8'hD0, 0);
    step(1, 8'hD1, 0);
    step(1, 8'hD2, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    total_cnt++; if (rd_valid !== 1'b1 || rd_data !== 8'hD0) $display("FAIL mid_pre_rst got v=%b d=%h want 1/d0", rd_valid, rd_data); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (rd_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1) $display("FAIL mid_async_rst got v=%b c=%0d e=%b want 0/0/1", rd_valid, count, empty); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL mid_rst_err got %b%b want 00", overflow, underflow); else pass_cnt++;
    step(0, 0, 0);
    rst = 1'b0;
    wr_n = 0; rd_n = 0;
    step(0, 0, 0);
    total_cnt++; if (rd_valid !== 1'b0 || empty !== 1'b1) $display("FAIL mid_release got v=%b e=%b want 0/1", rd_valid, empty); else pass_cnt++;
    step(1, 8'hE5, 0);
    total_cnt++; if (ram_w_addr !== 2'd0 || ram_w_en !== 1'b1) $display("FAIL mid_new_push got addr=%0d en=%b want 0/1", ram_w_addr, ram_w_en); else pass_cnt++;
    step(0, 0, 1);
    total_cnt++; if (ram_r_en !== 1'b1 || ram_r_addr !== 2'd0 || count !== 3'd1) $display("FAIL mid_new_pop got en=%b addr=%0d c=%0d want 1/0/1", ram_r_en, ram_r_addr, count); else pass_cnt++;
    step(0, 0, 0);
    total_cnt++; if (rd_valid !== 1'b1 || rd_data !== 8'hE5) $display("FAIL mid_new_data got v=%b d=%h want 1/e5", rd_valid, rd_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
